// File: rtl/urv_imem_line_responder_pkg.sv
// Shared types and field-width helpers for the uRV instruction line responder.
package urv_imem_line_responder_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StFill = 1'b1
    } imem_state_e;

    function automatic int unsigned word_bits(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Tag covers everything above the word index and the ignored byte offset.
    function automatic int unsigned tag_bits(input int unsigned addr_width,
                                             input int unsigned line_words);
        return addr_width - 2 - $clog2(line_words);
    endfunction

endpackage

// File: rtl/urv_imem_line_responder_if.sv
// Fetch-side and Wishbone-side signals of the instruction line responder.
interface urv_imem_line_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] im_addr_i;
    logic [31:0]           im_data_o;
    logic                  im_valid_o;
    logic                  inv_i;
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic                  wb_stall_i;
    logic                  wb_ack_i;
    logic [31:0]           wb_dat_i;

    modport slave (
        input  im_addr_i, inv_i, wb_stall_i, wb_ack_i, wb_dat_i,
        output im_data_o, im_valid_o, wb_cyc_o, wb_stb_o, wb_adr_o
    );

    modport master (
        output im_addr_i, inv_i, wb_stall_i, wb_ack_i, wb_dat_i,
        input  im_data_o, im_valid_o, wb_cyc_o, wb_stb_o, wb_adr_o
    );
endinterface

// File: rtl/urv_imem_line_responder_line_buf.sv
// Single instruction line: word storage, tag, valid flag and combinational hit compare.
module urv_imem_line_responder_line_buf #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned WORD_BITS  = 2,
    parameter int unsigned TAG_BITS   = 28
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [TAG_BITS-1:0]  lookup_tag,
    input  logic [WORD_BITS-1:0] rd_idx,
    output logic                 hit,
    output logic [31:0]          rd_data,
    input  logic                 wr_en,
    input  logic [WORD_BITS-1:0] wr_idx,
    input  logic [31:0]          wr_data,
    input  logic                 clr,
    input  logic                 commit,
    input  logic [TAG_BITS-1:0]  commit_tag,
    input  logic                 commit_valid
);
    logic [31:0]         words_q [LINE_WORDS];
    logic [TAG_BITS-1:0] tag_q;
    logic                valid_q;

    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            words_q[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else if (commit) begin
            tag_q   <= commit_tag;
            valid_q <= commit_valid;
        end else if (clr) begin
            valid_q <= 1'b0;
        end
    end

    assign hit     = valid_q && (tag_q == lookup_tag);
    assign rd_data = words_q[rd_idx];

endmodule

// File: rtl/urv_imem_line_responder.sv
// Responder end of the uRV instruction-fetch port: serves hits from one line buffer and
// refills it over a pipelined Wishbone read-only master on a miss.
module urv_imem_line_responder
    import urv_imem_line_responder_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic clk_i,
    input logic rst_i,
    urv_imem_line_responder_if.slave bus
);
    localparam int unsigned WordBits = word_bits(LINE_WORDS);
    localparam int unsigned TagBits  = tag_bits(ADDR_WIDTH, LINE_WORDS);
    localparam logic [WordBits-1:0] LastWord = WordBits'(LINE_WORDS - 1);

    imem_state_e state_q, state_d;

    logic [TagBits-1:0]    addr_tag, miss_tag_q;
    logic [WordBits-1:0]   addr_word, issue_cnt_q, ack_cnt_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [31:0]           im_data_q, line_rd_data;
    logic                  im_valid_q, cyc_q, stb_q, inv_seen_q;
    logic                  tag_hit, hit, start_fill, accept, ack, fill_done;
    logic                  unused_addr_bits;

    assign addr_tag         = bus.im_addr_i[ADDR_WIDTH-1 -: TagBits];
    assign addr_word        = bus.im_addr_i[2 +: WordBits];
    assign unused_addr_bits = ^bus.im_addr_i[1:0];

    urv_imem_line_responder_line_buf #(
        .LINE_WORDS(LINE_WORDS),
        .WORD_BITS (WordBits),
        .TAG_BITS  (TagBits)
    ) u_line_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .lookup_tag  (addr_tag),
        .rd_idx      (addr_word),
        .hit         (tag_hit),
        .rd_data     (line_rd_data),
        .wr_en       (ack),
        .wr_idx      (ack_cnt_q),
        .wr_data     (bus.wb_dat_i),
        .clr         (start_fill),
        .commit      (fill_done),
        .commit_tag  (miss_tag_q),
        .commit_valid(!(inv_seen_q || bus.inv_i))
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_fill) state_d = StFill;
            StFill: if (fill_done) state_d = StIdle;
        endcase
    end

    // An invalidate in the lookup cycle forces a miss even on a tag match.
    always_comb begin
        hit        = 1'b0;
        start_fill = 1'b0;
        accept     = 1'b0;
        ack        = 1'b0;
        unique case (state_q)
            StIdle: begin
                hit        = tag_hit && !bus.inv_i;
                start_fill = !hit;
            end
            StFill: begin
                accept = stb_q && !bus.wb_stall_i;
                ack    = cyc_q && bus.wb_ack_i;
            end
        endcase
    end

    assign fill_done = ack && (ack_cnt_q == LastWord);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            im_valid_q  <= 1'b0;
            im_data_q   <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= '0;
            miss_tag_q  <= '0;
            issue_cnt_q <= '0;
            ack_cnt_q   <= '0;
            inv_seen_q  <= 1'b0;
        end else begin
            im_valid_q <= hit;
            if (hit) begin
                im_data_q <= line_rd_data;
            end
            if (start_fill) begin
                miss_tag_q  <= addr_tag;
                cyc_q       <= 1'b1;
                stb_q       <= 1'b1;
                adr_q       <= {addr_tag, {(WordBits + 2){1'b0}}};
                issue_cnt_q <= '0;
                ack_cnt_q   <= '0;
                inv_seen_q  <= 1'b0;
            end else begin
                if (accept) begin
                    adr_q       <= adr_q + ADDR_WIDTH'(4);
                    issue_cnt_q <= issue_cnt_q + WordBits'(1);
                    if (issue_cnt_q == LastWord) begin
                        stb_q <= 1'b0;
                    end
                end
                if (ack) begin
                    ack_cnt_q <= ack_cnt_q + WordBits'(1);
                end
                if (state_q == StFill && bus.inv_i) begin
                    inv_seen_q <= 1'b1;
                end
                if (fill_done) begin
                    cyc_q <= 1'b0;
                end
            end
        end
    end

    assign bus.im_valid_o = im_valid_q;
    assign bus.im_data_o  = im_data_q;
    assign bus.wb_cyc_o   = cyc_q;
    assign bus.wb_stb_o   = stb_q;
    assign bus.wb_adr_o   = adr_q;

endmodule
